// File: rtl/sad_pkg.sv
// Shared constants, state encoding and saturation helper for the SAD minimum tracker.
package sad_pkg;

    localparam int SAD_LANES  = 16;
    localparam int SAD_GROUPS = SAD_LANES / 4;
    localparam logic [31:0] SAD_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sad_state_e;

    function automatic logic [31:0] sad_saturate(input logic [35:0] total);
        return (|total[35:32]) ? SAD_MAX : total[31:0];
    endfunction

endpackage

// File: rtl/sad_adder_tree.sv
// Two-stage 16-lane SAD adder: four 4-lane partial sums, then a 36-bit total,
// with coordinates and valid carried alongside. hold freezes, flush clears valids.
module sad_adder_tree
    import sad_pkg::*;
(
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        flush,
    input  logic                        hold,
    input  logic                        valid,
    input  logic [SAD_LANES-1:0][31:0]  lanes,
    input  logic [31:0]                 pos_x,
    input  logic [31:0]                 pos_y,
    output logic                        sum_valid,
    output logic [35:0]                 sum_total,
    output logic [31:0]                 sum_x,
    output logic [31:0]                 sum_y,
    output logic                        pending
);

    logic [33:0] part_next [SAD_GROUPS];
    logic [33:0] part_reg  [SAD_GROUPS];
    logic        s1_valid_reg;
    logic [31:0] s1_x_reg;
    logic [31:0] s1_y_reg;
    logic        s2_valid_reg;
    logic [35:0] s2_total_reg;
    logic [31:0] s2_x_reg;
    logic [31:0] s2_y_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SAD_GROUPS; gi++) begin : g_group
            assign part_next[gi] = {2'b00, lanes[4*gi]}   + {2'b00, lanes[4*gi+1]}
                                 + {2'b00, lanes[4*gi+2]} + {2'b00, lanes[4*gi+3]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else if (!hold) begin
            s1_valid_reg <= valid;
            s2_valid_reg <= s1_valid_reg;
        end
    end

    // Data registers need no reset: the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!hold) begin
            for (int g = 0; g < SAD_GROUPS; g++) begin
                part_reg[g] <= part_next[g];
            end
            s1_x_reg     <= pos_x;
            s1_y_reg     <= pos_y;
            s2_total_reg <= {2'b00, part_reg[0]} + {2'b00, part_reg[1]}
                          + {2'b00, part_reg[2]} + {2'b00, part_reg[3]};
            s2_x_reg     <= s1_x_reg;
            s2_y_reg     <= s1_y_reg;
        end
    end

    assign sum_valid = s2_valid_reg;
    assign sum_total = s2_total_reg;
    assign sum_x     = s2_x_reg;
    assign sum_y     = s2_y_reg;
    assign pending   = s1_valid_reg | s2_valid_reg;

endmodule

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD (and its coordinates) across a search of WindowCount results.
// Optional MinIndex output is enabled with `define SAD_MIN_INDEX_EN.
module sad_min_tracker
    import sad_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] WindowCount,
    input  logic        Stall,
    input  logic        sad_EX4,
    input  logic [31:0] In1_EX4,
    input  logic [31:0] In2_EX4,
    input  logic [31:0] In3_EX4,
    input  logic [31:0] In4_EX4,
    input  logic [31:0] In5_EX4,
    input  logic [31:0] In6_EX4,
    input  logic [31:0] In7_EX4,
    input  logic [31:0] In8_EX4,
    input  logic [31:0] In9_EX4,
    input  logic [31:0] In10_EX4,
    input  logic [31:0] In11_EX4,
    input  logic [31:0] In12_EX4,
    input  logic [31:0] In13_EX4,
    input  logic [31:0] In14_EX4,
    input  logic [31:0] In15_EX4,
    input  logic [31:0] In16_EX4,
    input  logic [31:0] outx_EX4,
    input  logic [31:0] outy_EX4,
    output logic [31:0] MinSad,
    output logic [31:0] MinX,
    output logic [31:0] MinY,
`ifdef SAD_MIN_INDEX_EN
    output logic [15:0] MinIndex,
`endif
    output logic        Busy,
    output logic        Done
);

    sad_state_e  state_reg   = ST_IDLE;
    sad_state_e  state_next;
    logic [15:0] count_reg   = 16'd0;
    logic [15:0] target_reg  = 16'd0;
    logic [31:0] min_sad_reg = SAD_MAX;
    logic [31:0] min_x_reg   = 32'd0;
    logic [31:0] min_y_reg   = 32'd0;
    logic        done_reg    = 1'b0;
    logic        done_next;

    logic [SAD_LANES-1:0][31:0] lanes;
    logic        accept;
    logic        sum_valid;
    logic [35:0] sum_total;
    logic [31:0] sum_sat;
    logic [31:0] sum_x;
    logic [31:0] sum_y;
    logic        pipe_pending;
    logic        better;

    assign lanes = {In16_EX4, In15_EX4, In14_EX4, In13_EX4, In12_EX4, In11_EX4, In10_EX4, In9_EX4,
                    In8_EX4,  In7_EX4,  In6_EX4,  In5_EX4,  In4_EX4,  In3_EX4,  In2_EX4,  In1_EX4};

    // Start wins over a simultaneous result, so that result is never counted.
    assign accept = (state_reg == ST_ACCUM) && sad_EX4 && !Stall && !Start;

    sad_adder_tree u_adder_tree (
        .clk       (Clk),
        .srst      (Reset),
        .flush     (Start),
        .hold      (Stall),
        .valid     (accept),
        .lanes     (lanes),
        .pos_x     (outx_EX4),
        .pos_y     (outy_EX4),
        .sum_valid (sum_valid),
        .sum_total (sum_total),
        .sum_x     (sum_x),
        .sum_y     (sum_y),
        .pending   (pipe_pending)
    );

    assign sum_sat = sad_saturate(sum_total);
    assign better  = sum_valid && (sum_sat < min_sad_reg);

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        if (Start) begin
            state_next = ST_ACCUM;
        end else if (!Stall) begin
            case (state_reg)
                ST_ACCUM: begin
                    if (target_reg == 16'd0) begin
                        state_next = ST_DONE;
                    end else if (accept && (count_reg + 16'd1 == target_reg)) begin
                        state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!pipe_pending) begin
                        state_next = ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
        done_next = (state_next == ST_DONE) && (state_reg != ST_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= ST_IDLE;
            count_reg   <= 16'd0;
            target_reg  <= 16'd0;
            min_sad_reg <= SAD_MAX;
            min_x_reg   <= 32'd0;
            min_y_reg   <= 32'd0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (Start) begin
                count_reg   <= 16'd0;
                target_reg  <= WindowCount;
                min_sad_reg <= SAD_MAX;
                min_x_reg   <= 32'd0;
                min_y_reg   <= 32'd0;
            end else if (!Stall) begin
                if (accept) begin
                    count_reg <= count_reg + 16'd1;
                end
                // Strict less-than keeps the earlier result on a tie.
                if (better) begin
                    min_sad_reg <= sum_sat;
                    min_x_reg   <= sum_x;
                    min_y_reg   <= sum_y;
                end
            end
        end
    end

`ifdef SAD_MIN_INDEX_EN
    logic [15:0] s1_idx_reg;
    logic [15:0] s2_idx_reg;
    logic [15:0] min_index_reg = 16'd0;

    // Ordinal of each accepted result travels in step with the adder pipeline.
    always_ff @(posedge Clk) begin
        if (!Stall) begin
            s1_idx_reg <= count_reg;
            s2_idx_reg <= s1_idx_reg;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || Start) begin
            min_index_reg <= 16'd0;
        end else if (!Stall && better) begin
            min_index_reg <= s2_idx_reg;
        end
    end

    assign MinIndex = min_index_reg;
`endif

    assign MinSad = min_sad_reg;
    assign MinX   = min_x_reg;
    assign MinY   = min_y_reg;
    assign Busy   = (state_reg == ST_ACCUM) || (state_reg == ST_DRAIN);
    assign Done   = done_reg;

endmodule

// File: doc/sad_min_tracker.md
SAD_MIN_TRACKER -- requirements
Module: sad_min_tracker

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock; all state updates on posedge Clk.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset sampled on posedge Clk.
REQ-003 SHALL have port Start, input, 1, which clears the tracker and begins a new search.
REQ-004 SHALL have port WindowCount, input, 16, the number of SAD results in the search; sampled when Start=1.
REQ-005 SHALL have port Stall, input, 1, which freezes all internal state when high.
REQ-006 SHALL have port sad_EX4, input, 1, the valid flag for one custom-SAD result from the EX4 stage.
REQ-007 SHALL have ports In1_EX4..In16_EX4, input, 32 each, the per-pixel absolute differences of one window.
REQ-008 SHALL have ports outx_EX4 and outy_EX4, input, 32 each, the window coordinates paired with the In lanes.
REQ-009 SHALL have ports MinSad, MinX and MinY, output, 32 each, the best SAD so far and its coordinates.
REQ-010 SHALL have port Busy, output, 1, high in ACCUM and DRAIN.
REQ-011 SHALL have port Done, output, 1, a one-cycle pulse on entry to DONE.

Function
REQ-012 SHALL implement the states IDLE, ACCUM, DRAIN and DONE.
REQ-013 SHALL move from IDLE or DONE to ACCUM on Start=1, loading the count and setting MinSad=32'hFFFF_FFFF and MinX=MinY=0.
REQ-014 SHALL accept a result only when state=ACCUM, sad_EX4=1 and Stall=0; sad_EX4 in any other state SHALL be ignored.
REQ-015 SHALL add the 16 lanes through a 2-stage pipeline: stage 1 forms four 4-lane partial sums, stage 2 forms the 36-bit total.
REQ-016 SHALL carry the coordinates and a valid bit alongside the sums.
REQ-017 SHALL saturate the total to 32'hFFFF_FFFF if it exceeds 32 bits.
REQ-018 SHALL replace MinSad, MinX and MinY with the new total and coordinates in a compare stage only if the total is strictly less than MinSad; on a tie the earlier result is kept.
REQ-019 SHALL make the accepted result visible on MinSad exactly 3 cycles after acceptance, with no stall.
REQ-020 SHALL go from ACCUM to DRAIN on the cycle the accepted-result count reaches WindowCount.
REQ-021 SHALL go from DRAIN to DONE once all pipeline valid bits are clear, and SHALL pulse Done for one cycle on that transition.
REQ-022 SHALL, when WindowCount=0, go ACCUM→DONE on the next cycle with MinSad=32'hFFFF_FFFF.
REQ-023 SHALL hold outputs stable in DONE until the next Start.
REQ-024 SHALL, on Start during ACCUM or DRAIN, abort the current search: clear the pipeline valid bits, reinitialise the outputs and enter ACCUM. No Done pulse is produced for the aborted search.
REQ-025 SHALL, while Stall=1, hold all pipeline stages, the counter, the state and the outputs; Start SHALL still take effect during Stall.
REQ-026 SHALL give Start priority over a simultaneous sad_EX4; that result is not counted.

Reset
REQ-027 SHALL, on Reset=1 at posedge Clk, set state=IDLE, clear all pipeline valid bits and the counter, and set MinSad=32'hFFFF_FFFF, MinX=0, MinY=0, Busy=0 and Done=0.
REQ-028 SHALL give Reset priority over Start, Stall and sad_EX4; Reset in mid-search SHALL discard the search without a Done pulse.
REQ-029 SHALL also apply the reset values of REQ-027 through initial values at power-up.

Configuration
REQ-030 SHALL, when SAD_MIN_INDEX_EN is defined, add output MinIndex (16 bits): the 0-based ordinal of the winning accepted result, reset to 0 and updated together with MinSad.
REQ-031 SHALL, when SAD_MIN_INDEX_EN is not defined, have no MinIndex port or index counter, with all other behaviour identical.

Structure
REQ-032 SHALL place SAD_LANES=16, SAD_MAX=32'hFFFF_FFFF and the state encoding in shared package sad_pkg.
REQ-033 SHALL implement the 2-stage 16-lane adder with its valid and coordinate side-band as sub-module sad_adder_tree.

Verification
REQ-034 SHALL pass this scenario: WindowCount=3; results with all lanes=1 at (0,0), all lanes=0 at (4,8), all lanes=2 at (8,0) → MinSad=0, MinX=4, MinY=8, one Done pulse.
REQ-035 SHALL pass this scenario: tie, with totals 16 at (1,1) then 16 at (2,2) → MinX=1, MinY=1.
REQ-036 SHALL pass this scenario: one lane=32'hFFFF_FFFF and the other lanes=5 → total saturates, MinSad=32'hFFFF_FFFF, and a later total of 100 replaces it.
REQ-037 SHALL pass this scenario: Stall held for 4 cycles between two accepted results → latency extended by exactly 4 cycles, with no lost or duplicated result.
REQ-038 SHALL pass this scenario: Start asserted in the second cycle of DRAIN → no Done pulse, MinSad=32'hFFFF_FFFF, and the new search completes correctly.
REQ-039 SHALL pass this scenario: WindowCount=0 → Done one cycle after entering ACCUM, MinSad=32'hFFFF_FFFF; and Reset in mid-ACCUM → IDLE with all outputs at reset values.
